// File: rtl/fht_butterfly_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fht_butterfly_pkg
//  Description : Shared constants and helpers for the FHT butterfly datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package fht_butterfly_pkg;

    // Default data and twiddle widths
    localparam int c_D_BIT_DEF      = 16;
    localparam int c_W_BIT_DEF      = 16;

    // Twiddle unit: MAX_W represents 1.0, HALF_W_MAX is the rounding offset
    localparam int c_HALF_W_MAX_DEF = 8192;
    localparam int c_MAX_W_DEF      = 2 * c_HALF_W_MAX_DEF;

    // Right shift that divides by MAX_W
    localparam int c_SHIFT_DEF      = $clog2(c_MAX_W_DEF);

    // Clamp a signed value into the signed range of 'bits' bits.
    // Operates on a 64-bit container so callers of any width <= 64 can use it.
    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] v,
        input int unsigned        bits
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bits - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fht_butterfly.sv
`default_nettype none
// ============================================================================
//  Module      : fht_butterfly
//  Description : Two-stage pipelined radix-2 FHT butterfly. Stage 1 rotates
//                (x1, x2) by the twiddle and rounds; stage 2 forms x0 +/- rot,
//                halves with rounding and saturates to the data range.
//  Revision    : 1.0 - initial release
// ============================================================================
module fht_butterfly
    import fht_butterfly_pkg::*;
#(
    parameter int D_BIT      = c_D_BIT_DEF,
    parameter int W_BIT      = c_W_BIT_DEF,
    parameter int HALF_W_MAX = c_HALF_W_MAX_DEF
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic signed [D_BIT-1:0] iX_0,
    input  logic signed [D_BIT-1:0] iX_1,
    input  logic signed [D_BIT-1:0] iX_2,
    input  logic signed [W_BIT-1:0] iSIN,
    input  logic signed [W_BIT-1:0] iCOS,
    output logic signed [D_BIT-1:0] oY_0,
    output logic signed [D_BIT-1:0] oY_1
);

    localparam int c_MAX_W = 2 * HALF_W_MAX;
    localparam int c_SHIFT = $clog2(c_MAX_W);
    localparam int c_PW    = D_BIT + W_BIT;      // single product width
    localparam int c_SW    = D_BIT + W_BIT + 1;  // product-sum width
    localparam int c_RW    = D_BIT + 2;          // rotated value width
    localparam int c_OW    = D_BIT + 3;          // add/sub width

    // ---------------- stage 1: rotation and rounding ----------------
    logic signed [c_PW-1:0] w_p_cos;
    logic signed [c_PW-1:0] w_p_sin;
    logic signed [c_SW-1:0] w_sum;
    logic signed [c_SW-1:0] w_rnd;
    logic signed [c_SW-1:0] w_shf;
    logic signed [c_RW-1:0] w_rot;
    logic signed [c_RW-1:0] r_rot;

    assign w_p_cos = iCOS * iX_1;
    assign w_p_sin = iSIN * iX_2;
    assign w_sum   = {w_p_cos[c_PW-1], w_p_cos} + {w_p_sin[c_PW-1], w_p_sin};
    // Adding half a unit then flooring rounds halves toward +inf
    assign w_rnd   = w_sum + $signed(c_SW'(HALF_W_MAX));
    assign w_shf   = w_rnd >>> c_SHIFT;
    // |rot| <= sqrt(2)*2^(D_BIT-1), so the low D_BIT+2 bits hold it exactly
    assign w_rot   = w_shf[c_RW-1:0];

    // ---------------- stage 2: add/sub, halve, saturate ----------------
    logic signed [c_OW-1:0] w_x0_ext;
    logic signed [c_OW-1:0] w_rot_ext;
    logic signed [c_OW-1:0] w_s0;
    logic signed [c_OW-1:0] w_s1;
    logic signed [c_OW-1:0] w_h0;
    logic signed [c_OW-1:0] w_h1;
    logic signed [63:0]     w_sat0;
    logic signed [63:0]     w_sat1;
    logic signed [D_BIT-1:0] r_y0;
    logic signed [D_BIT-1:0] r_y1;

    assign w_x0_ext  = {{3{iX_0[D_BIT-1]}}, iX_0};
    assign w_rot_ext = {r_rot[c_RW-1], r_rot};
    assign w_s0      = w_x0_ext + w_rot_ext;
    assign w_s1      = w_x0_ext - w_rot_ext;
    // (s + 1) >>> 1 halves with round-half-up
    assign w_h0      = (w_s0 + $signed(c_OW'(1))) >>> 1;
    assign w_h1      = (w_s1 + $signed(c_OW'(1))) >>> 1;
    assign w_sat0    = sat_signed({{(64-c_OW){w_h0[c_OW-1]}}, w_h0}, D_BIT);
    assign w_sat1    = sat_signed({{(64-c_OW){w_h1[c_OW-1]}}, w_h1}, D_BIT);

    // Stage 1 register: rounded rotation of (x1, x2)
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET)
            r_rot <= '0;
        else
            r_rot <= w_rot;
    end

    // Stage 2 registers: saturated, halved sum and difference
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_y0 <= '0;
            r_y1 <= '0;
        end else begin
            r_y0 <= w_sat0[D_BIT-1:0];
            r_y1 <= w_sat1[D_BIT-1:0];
        end
    end

    assign oY_0 = r_y0;
    assign oY_1 = r_y1;

endmodule
`default_nettype wire

// File: tb/tb_fht_butterfly.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fht_butterfly
//  Description : Self-checking bench for fht_butterfly: directed vector table,
//                reset sequences and an accuracy sweep against real arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fht_butterfly;

    logic               clk;
    logic               rst_n;
    logic signed [15:0] x0, x1, x2, sn, cs;
    logic signed [15:0] y0, y1;

    int n_checks = 0;
    int n_pass   = 0;

    fht_butterfly dut (
        .iCLK   (clk),
        .iRESET (rst_n),
        .iX_0   (x0),
        .iX_1   (x1),
        .iX_2   (x2),
        .iSIN   (sn),
        .iCOS   (cs),
        .oY_0   (y0),
        .oY_1   (y1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cs; int sn; int x1; int x2; int x0; int y0; int y1;
    } vec_t;

    vec_t vt[7];

    // accuracy sweep storage
    localparam int NR = 64 + 1000;
    int ac[NR], as_[NR], a1[NR], a2[NR], a0[NR];
    int ang_c[8] = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585};
    int ang_s[8] = '{0, 11585, 16384, 11585, 0, -11585, -16384, -11585};

    task automatic chk_eq(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    endtask

    task automatic chk_acc(input string nm, input int idx, input int act, input real ideal);
        bit ok;
        n_checks++;
        if (ideal > 32767.0)       ok = (act == 32767);
        else if (ideal < -32768.0) ok = (act == -32768);
        else                       ok = ((act - ideal) < 1.0) && ((ideal - act) < 1.0);
        if (ok) n_pass++;
        else $display("FAIL %s[%0d]: got %0d expected %f", nm, idx, act, ideal);
    endtask

    task automatic drive_idle();
        x0 = 0; x1 = 0; x2 = 0; sn = 0; cs = 0;
    endtask

    initial begin
        real ideal_rot;
        int  bits;

        // {cos, sin, x1, x2, x0, y0, y1}
        vt[0] = '{16384,      0,    100,     -7,     50,     75,    -25};
        vt[1] = '{    0,  12288,      0,      2,      0,      1,     -1};
        vt[2] = '{11585,  11585,  32767,  32767,  32767,  32767,  -6786};
        vt[3] = '{-16384,     0, -32768,      0, -32768,      0, -32768};
        vt[4] = '{    0,  16384,      0,   -100,     10,    -45,     55};
        vt[5] = '{-11585, 11585,   1000,   3000,  -2000,   -293,  -1707};
        vt[6] = '{11585,  11585, -32768, -32768, -32768, -32768,   6786};

        // ---- asynchronous reset before any clock edge ----
        rst_n = 1'b0;
        x0 = 16'sd1234; x1 = 16'sd999; x2 = -16'sd5; cs = 16'sd16384; sn = 16'sd0;
        #1;
        chk_eq("reset_y0", int'(y0), 0);
        chk_eq("reset_y1", int'(y1), 0);
        @(posedge clk); #1;
        chk_eq("reset_held_y0", int'(y0), 0);
        chk_eq("reset_held_y1", int'(y1), 0);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;

        // ---- directed table, back-to-back ----
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            if (i < 7) begin
                cs = 16'(vt[i].cs); sn = 16'(vt[i].sn);
                x1 = 16'(vt[i].x1); x2 = 16'(vt[i].x2);
            end else begin
                cs = 0; sn = 0; x1 = 0; x2 = 0;
            end
            x0 = (i > 0) ? 16'(vt[i-1].x0) : 16'sd0;
            @(posedge clk); #1;
            if (i > 0) begin
                chk_eq($sformatf("vec%0d_y0", i-1), int'(y0), vt[i-1].y0);
                chk_eq($sformatf("vec%0d_y1", i-1), int'(y1), vt[i-1].y1);
            end
        end

        // ---- async reset mid-operation (outputs currently nonzero) ----
        @(negedge clk);
        cs = 16'sd16384; sn = 0; x1 = 16'sd100; x2 = 0; x0 = 16'sd40;
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("midreset_async_y0", int'(y0), 0);
        chk_eq("midreset_async_y1", int'(y1), 0);
        @(posedge clk); #1;
        chk_eq("midreset_held_y0", int'(y0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        // first edge after release: rot register is still cleared
        @(posedge clk); #1;
        chk_eq("post_reset_y0", int'(y0), 20);
        chk_eq("post_reset_y1", int'(y1), 20);
        // second edge: rot=100 now reaches stage 2
        @(posedge clk); #1;
        chk_eq("post_reset2_y0", int'(y0), 70);
        chk_eq("post_reset2_y1", int'(y1), -30);

        // ---- accuracy sweep: special angles x full-scale data, then random ----
        for (int k = 0; k < 64; k++) begin
            bits   = k % 8;
            ac[k]  = ang_c[k / 8];
            as_[k] = ang_s[k / 8];
            a1[k]  = bits[0] ? 32767 : -32768;
            a2[k]  = bits[1] ? 32767 : -32768;
            a0[k]  = bits[2] ? 32767 : -32768;
        end
        for (int k = 64; k < NR; k++) begin
            real ang;
            ang    = real'($urandom_range(0, 35999)) * 3.14159265358979 / 18000.0;
            ac[k]  = $rtoi($floor(16384.0 * $cos(ang) + 0.5));
            as_[k] = $rtoi($floor(16384.0 * $sin(ang) + 0.5));
            a1[k]  = int'($urandom_range(0, 65535)) - 32768;
            a2[k]  = int'($urandom_range(0, 65535)) - 32768;
            a0[k]  = int'($urandom_range(0, 65535)) - 32768;
        end
        for (int i = 0; i <= NR; i++) begin
            @(negedge clk);
            if (i < NR) begin
                cs = 16'(ac[i]); sn = 16'(as_[i]); x1 = 16'(a1[i]); x2 = 16'(a2[i]);
            end else begin
                cs = 0; sn = 0; x1 = 0; x2 = 0;
            end
            x0 = (i > 0) ? 16'(a0[i-1]) : 16'sd0;
            @(posedge clk); #1;
            if (i > 0) begin
                ideal_rot = (real'(ac[i-1]) * real'(a1[i-1]) +
                             real'(as_[i-1]) * real'(a2[i-1])) / 16384.0;
                chk_acc("sweep_y0", i-1, int'(y0), (real'(a0[i-1]) + ideal_rot) / 2.0);
                chk_acc("sweep_y1", i-1, int'(y1), (real'(a0[i-1]) - ideal_rot) / 2.0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
